// File: rtl/keccak_pad.sv
// keccak_pad: packs a byte stream into rate blocks and applies SHA3 pad10*1.
// Define KECCAK_PAD_SHAKE_EN to add in_shake, selecting the SHAKE suffix 0x1F.
module keccak_pad #(
  parameter  int l  = 6,
  parameter  int d  = 112,
  localparam int r  = 25 * (2 ** l) - 2 * d,
  localparam int R  = r / 8,
  localparam int cw = $clog2(R)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
`ifdef KECCAK_PAD_SHAKE_EN
  input  logic         in_shake,
`endif
  output logic         in_ready,
  output logic [r-1:0] message,
  output logic         absorb,
  output logic         last_block,
  output logic         sponge_clear
);

  typedef enum logic [2:0] {
    CLEAR,
    FILL,
    ABSORB,
    PAD,
    FINAL
  } state_t;

  localparam logic [cw-1:0] last_idx = cw'(R - 1);

  state_t              state;
  state_t              state_nxt;
  logic [R-1:0][7:0]   buffer;
  logic [cw-1:0]       cnt;
  logic                pad_pending;
  logic                accept;
  logic [7:0]          suffix;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      CLEAR:  state_nxt = FILL;
      FILL: begin
        if (in_valid) begin
          accept = 1'b1;
          if (cnt == last_idx) state_nxt = ABSORB;
          else if (in_last)    state_nxt = PAD;
        end
      end
      ABSORB: state_nxt = pad_pending ? PAD : FILL;
      PAD:    state_nxt = FINAL;
      FINAL:  state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buffer      <= '0;
      cnt         <= '0;
      pad_pending <= 1'b0;
    end else begin
      unique case (state)
        CLEAR, ABSORB: begin
          buffer      <= '0;
          cnt         <= '0;
          pad_pending <= 1'b0;
        end
        FILL: begin
          if (accept) begin
            buffer[cnt] <= in_data;
            if (cnt == last_idx) pad_pending <= in_last;
            else                 cnt <= cnt + 1'b1;
          end
        end
        PAD: begin
          // last assignment wins, so fold the suffix in when both land on R-1
          buffer[cnt]      <= buffer[cnt] | suffix;
          buffer[last_idx] <= buffer[last_idx] | 8'h80 |
                              ((cnt == last_idx) ? suffix : 8'h00);
        end
        default: ;
      endcase
    end
  end

`ifdef KECCAK_PAD_SHAKE_EN
  logic shake_q;
  logic first_q;

  // only the first byte of a message picks the domain, not continuation blocks
  always_ff @(posedge clk) begin
    if (reset || state == CLEAR) begin
      shake_q <= 1'b0;
      first_q <= 1'b1;
    end else if (accept && first_q) begin
      shake_q <= in_shake;
      first_q <= 1'b0;
    end
  end

  assign suffix = shake_q ? 8'h1F : 8'h06;
`else
  assign suffix = 8'h06;
`endif

  assign in_ready     = ~reset & (state == FILL);
  assign absorb       = ~reset & ((state == ABSORB) | (state == FINAL));
  assign last_block   = ~reset & (state == FINAL);
  assign sponge_clear = ~reset & (state == CLEAR);
  assign message      = reset ? '0 : buffer;

endmodule
